// File: rtl/sd_sector_loader.sv
// Multi-sector SD block read sequencer: streams controller bytes into cartridge RAM with retry on timeout.
// Optional running byte checksum is built only when SD_LOADER_CHECKSUM_EN is defined.
module sd_sector_loader #(
  parameter int MEM_AW      = 17,
  parameter int MAX_RETRIES = 3,
  parameter bit BLOCK_ADDR  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       start_sector,
  input  logic [15:0]       sector_count,
  input  logic [MEM_AW-1:0] mem_base,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       sectors_done,
  output logic [15:0]       checksum,
  input  logic              sd_ready,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic [7:0]        sd_dout,
  input  logic              sd_byte_available,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_wait
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, ISSUE, STREAM, DRAIN, GAP, ERR
  } state_t;

  state_t            state, next_state;
  logic [31:0]       sector;
  logic [15:0]       count;
  logic [MEM_AW-1:0] blk_base;
  logic [7:0]        retries;
  logic [9:0]        byte_cnt;
  logic [7:0]        hold;
  logic              hold_full, hold_full_next, bav_prev;
  logic              active, capture, wr_done, accept, timeout, retry;

  assign active    = (state == ISSUE) || (state == STREAM) || (state == DRAIN);
  assign capture   = active && sd_byte_available && !bav_prev;
  assign wr_done   = hold_full && !mem_wait;
  assign accept    = (state == IDLE) && start && (sector_count != 16'd0);
  assign timeout   = (state == STREAM) && (byte_cnt < 10'd512) && sd_ready;
  assign retry     = timeout && (retries < 8'(MAX_RETRIES));
  assign mem_we    = hold_full;
  assign mem_wdata = hold;

  always_comb begin
    next_state     = state;
    hold_full_next = hold_full;
    if (wr_done) hold_full_next = 1'b0;
    if (capture) hold_full_next = 1'b1;
    // A timed-out sector's pending byte is stale; it will be re-read.
    if (timeout) hold_full_next = 1'b0;
    case (state)
      IDLE:     if (accept) next_state = WAIT_RDY;
      WAIT_RDY: if (sd_ready) next_state = ISSUE;
      ISSUE:    if (!sd_ready) next_state = STREAM;
      STREAM: begin
        if (byte_cnt == 10'd512) next_state = DRAIN;
        else if (sd_ready) next_state = retry ? GAP : ERR;
      end
      DRAIN:    if (sd_ready && !hold_full) next_state = GAP;
      GAP:      next_state = (sectors_done == count) ? IDLE : WAIT_RDY;
      ERR:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      sectors_done <= 16'd0;
      sd_rd        <= 1'b0;
      sd_address   <= 32'd0;
      mem_addr     <= '0;
      hold         <= 8'd0;
      hold_full    <= 1'b0;
      bav_prev     <= 1'b0;
      byte_cnt     <= 10'd0;
      retries      <= 8'd0;
    end else begin
      done      <= 1'b0;
      bav_prev  <= sd_byte_available;
      hold_full <= hold_full_next;
      // Registered from next-cycle state so rd is already low while the holding byte waits for RAM.
      sd_rd     <= ((next_state == ISSUE) || (next_state == STREAM) || (next_state == DRAIN))
                   && !hold_full_next;
      if (capture) begin
        hold     <= sd_dout;
        byte_cnt <= byte_cnt + 10'd1;
      end
      if (wr_done) mem_addr <= mem_addr + 1'b1;
      case (state)
        IDLE: begin
          if (start && (sector_count == 16'd0)) begin
            done <= 1'b1;
          end else if (accept) begin
            busy         <= 1'b1;
            error        <= 1'b0;
            sectors_done <= 16'd0;
            mem_addr     <= mem_base;
            retries      <= 8'd0;
          end
        end
        WAIT_RDY: begin
          if (sd_ready) begin
            sd_address <= BLOCK_ADDR ? sector : {sector[22:0], 9'd0};
            byte_cnt   <= 10'd0;
          end
        end
        STREAM: begin
          if (byte_cnt != 10'd512 && retry) begin
            retries  <= retries + 8'd1;
            mem_addr <= blk_base;
          end
        end
        DRAIN: begin
          if (sd_ready && !hold_full) begin
            sectors_done <= sectors_done + 16'd1;
            retries      <= 8'd0;
          end
        end
        GAP: begin
          if (sectors_done == count) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sector <= start_sector;
      count  <= sector_count;
    end else if (state == DRAIN && sd_ready && !hold_full) begin
      sector <= sector + 32'd1;
    end
    if (state == WAIT_RDY && sd_ready) blk_base <= mem_addr;
  end

`ifdef SD_LOADER_CHECKSUM_EN
  logic [15:0] sum, snap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                sum <= 16'd0;
    else if (accept)          sum <= 16'd0;
    else if (retry)           sum <= snap;
    else if (wr_done)         sum <= sum + {8'h00, hold};
  end

  // Snapshot at command issue so a retried sector's partial bytes drop out of the sum.
  always_ff @(posedge clk) begin
    if (state == WAIT_RDY && sd_ready) snap <= sum;
  end

  assign checksum = sum;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sd_sector_loader.sv
// Bench for sd_sector_loader: SD controller and RAM models drive two DUTs (byte and block addressing).
module tb_sd_sector_loader;
  localparam int AW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, sd_ready, sd_byte_available, mem_wait;
  logic [31:0]   start_sector;
  logic [15:0]   sector_count;
  logic [AW-1:0] mem_base;
  logic [7:0]    sd_dout;

  logic          busy0, done0, error0, rd0, we0, busy1, done1, error1, rd1, we1;
  logic [15:0]   sd0, cs0, sd1, cs1;
  logic [31:0]   addr0, addr1;
  logic [AW-1:0] ma0, ma1;
  logic [7:0]    wd0, wd1;

  sd_sector_loader #(.MEM_AW(AW), .MAX_RETRIES(3), .BLOCK_ADDR(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .mem_base(mem_base), .busy(busy0), .done(done0),
    .error(error0), .sectors_done(sd0), .checksum(cs0), .sd_ready(sd_ready), .sd_rd(rd0),
    .sd_address(addr0), .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
    .mem_we(we0), .mem_addr(ma0), .mem_wdata(wd0), .mem_wait(mem_wait));

  sd_sector_loader #(.MEM_AW(AW), .MAX_RETRIES(3), .BLOCK_ADDR(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .mem_base(mem_base), .busy(busy1), .done(done1),
    .error(error1), .sectors_done(sd1), .checksum(cs1), .sd_ready(sd_ready), .sd_rd(rd1),
    .sd_address(addr1), .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
    .mem_we(we1), .mem_addr(ma1), .mem_wdata(wd1), .mem_wait(mem_wait));

  int total = 0;
  int bad = 0;

  logic [7:0]    ram [0:(1<<AW)-1];
  int            writes = 0, rd_viol = 0, diverge = 0, done_cnt = 0, stall_hits = 0;
  int            stall_req = 0, stall_done_id = 0, stall_left = 0;
  logic [AW-1:0] stall_addr = '0;
  int            fails_used = 0, fail_limit = 0;
  logic [7:0]    seed = 8'h00;
  logic [31:0]   addr0_q[$], addr1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_rd(output bit ab);
    int g;
    g = 0;
    ab = 1'b0;
    while (!rd0) begin
      if (reset || g > 3000) begin
        ab = 1'b1;
        return;
      end
      @(negedge clk);
      g++;
    end
    if (reset) ab = 1'b1;
  endtask

  // SD controller: waits for rd in idle, drops ready, streams bytes only while rd is high.
  initial begin
    bit bad_try, abort;
    int nb;
    sd_ready = 1'b1;
    sd_byte_available = 1'b0;
    sd_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (rd0 && !reset) begin
        addr0_q.push_back(addr0);
        addr1_q.push_back(addr1);
        repeat (2) @(negedge clk);
        sd_ready = 1'b0;
        bad_try = (fails_used < fail_limit);
        nb = bad_try ? 37 : 512;
        abort = 1'b0;
        for (int i = 0; i < nb; i++) begin
          wait_rd(abort);
          if (abort) break;
          sd_dout = bad_try ? (8'(i) ^ 8'hA5) : (8'(i) ^ seed);
          sd_byte_available = 1'b1;
          repeat (2) @(negedge clk);
          sd_byte_available = 1'b0;
          @(negedge clk);
        end
        if (!abort) begin
          if (bad_try) begin
            fails_used++;
            repeat (5) @(negedge clk);
          end else begin
            wait_rd(abort);
            repeat (3) @(negedge clk);
          end
        end
        sd_ready = 1'b1;
        sd_byte_available = 1'b0;
        repeat (10) @(negedge clk);
      end
    end
  end

  // RAM model and running monitors, evaluated away from the active edge.
  initial begin
    mem_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_wait = 1'b0;
        stall_left = 0;
      end else begin
        if (done0) done_cnt++;
        if (we0 && rd0) rd_viol++;
        if ({busy0, done0, error0, rd0, we0, ma0, wd0, sd0, cs0} !==
            {busy1, done1, error1, rd1, we1, ma1, wd1, sd1, cs1}) diverge++;
        if (stall_left > 0) begin
          stall_left--;
        end else if (stall_done_id != stall_req && we0 && ma0 == stall_addr) begin
          stall_done_id = stall_req;
          stall_left = 20;
        end
        mem_wait = (stall_left > 0);
        if (we0 && !mem_wait) begin
          ram[ma0] = wd0;
          writes++;
          if (ma0 == stall_addr) stall_hits++;
        end
      end
    end
  end

  typedef struct {
    logic [31:0]   sector;
    logic [15:0]   count;
    logic [AW-1:0] base;
    logic [7:0]    seed;
    bit            stall;
    int            timeouts;
    bit            exp_err;
    int            exp_done;
    logic [15:0]   exp_sd;
    int            exp_issues;
    int            exp_writes;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    int ib, db, wb, rvb, dvb, shb, g, rd_seen, nmis;
    logic [31:0]   sec;
    logic [AW-1:0] a;
    logic [15:0]   ecs;
    vec_t v;

    //          sector         cnt    base       seed  stall to err done sd  iss  writes
    vecs[0] = '{32'd5,         16'd1, 17'h00100, 8'h00, 1'b0, 0, 1'b0, 1, 16'd1, 1, 512};
    vecs[1] = '{32'd2,         16'd3, 17'h04000, 8'h3C, 1'b0, 0, 1'b0, 1, 16'd3, 3, 1536};
    vecs[2] = '{32'd9,         16'd1, 17'h1FF00, 8'h5A, 1'b1, 0, 1'b0, 1, 16'd1, 1, 512};
    vecs[3] = '{32'hFFFFFFFF,  16'd2, 17'h00000, 8'h01, 1'b0, 1, 1'b0, 1, 16'd2, 3, 1061};
    vecs[4] = '{32'd7,         16'd2, 17'h00800, 8'h02, 1'b0, 4, 1'b1, 0, 16'd0, 4, 148};
    vecs[5] = '{32'd100,       16'd1, 17'h03000, 8'h77, 1'b0, 0, 1'b0, 1, 16'd1, 1, 512};

    reset = 1'b1;
    start = 1'b0;
    start_sector = 32'd0;
    sector_count = 16'd0;
    mem_base = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_error", error0, 0);
    check("rst_rd", rd0, 0);
    check("rst_we", we0, 0);
    check("rst_sectors_done", sd0, 0);
    check("rst_checksum", cs0, 0);
    check("rst_sd_address", addr1, 0);
    check("rst_mem_addr", ma0, 0);
    check("rst_mem_wdata", wd0, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Zero sector count: done on the next cycle, no read ever issued.
    db = done_cnt;
    ib = addr0_q.size();
    start_sector = 32'd44;
    sector_count = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", done0, 1);
    check("zero_busy", busy0, 0);
    rd_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd0) rd_seen++;
    end
    check("zero_rd_never", rd_seen, 0);
    check("zero_done_once", done_cnt - db, 1);
    check("zero_no_issue", addr0_q.size() - ib, 0);

    // Reset in the middle of a sector stream.
    seed = 8'h11;
    start_sector = 32'd3;
    sector_count = 16'd1;
    mem_base = 17'h00200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(ma0 >= 17'h00232 && rd0) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check("mid_reached_stream", (ma0 >= 17'h00232 && rd0), 1);
    check("mid_busy_before", busy0, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rd_cleared", rd0, 0);
    check("mid_we_cleared", we0, 0);
    check("mid_busy_cleared", busy0, 0);
    check("mid_mem_addr_cleared", ma0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < NV; t++) begin
      v = vecs[t];
      ib = addr0_q.size();
      db = done_cnt;
      wb = writes;
      rvb = rd_viol;
      dvb = diverge;
      shb = stall_hits;
      seed = v.seed;
      fail_limit = fails_used + v.timeouts;
      if (v.stall) begin
        stall_addr = v.base + AW'(100);
        stall_req++;
      end
      start_sector = v.sector;
      sector_count = v.count;
      mem_base = v.base;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      if (busy0) begin
        start_sector = 32'h0000BAD0;
        sector_count = 16'd5;
        mem_base = 17'h10000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      g = 0;
      while (busy0 && g < 30000) begin
        @(negedge clk);
        g++;
      end
      check($sformatf("t%0d_terminates", t), busy0, 0);
      repeat (40) @(negedge clk);

      check($sformatf("t%0d_error", t), error0, v.exp_err);
      check($sformatf("t%0d_done_pulses", t), done_cnt - db, v.exp_done);
      check($sformatf("t%0d_sectors_done", t), sd0, v.exp_sd);
      check($sformatf("t%0d_issues", t), addr0_q.size() - ib, v.exp_issues);
      nmis = 0;
      for (int k = 0; k < v.exp_issues && ib + k < addr0_q.size(); k++) begin
        sec = v.sector + ((k <= v.timeouts) ? 32'd0 : 32'(k - v.timeouts));
        if (addr0_q[ib + k] !== (sec << 9)) nmis++;
        if (addr1_q[ib + k] !== sec) nmis++;
      end
      check($sformatf("t%0d_sd_address", t), nmis, 0);
      check($sformatf("t%0d_ram_writes", t), writes - wb, v.exp_writes);
      check($sformatf("t%0d_rd_while_we", t), rd_viol - rvb, 0);
      check($sformatf("t%0d_dut_agree", t), diverge - dvb, 0);
      if (v.stall) check($sformatf("t%0d_stall_byte_once", t), stall_hits - shb, 1);
      if (!v.exp_err) begin
        nmis = 0;
        ecs = 16'h0000;
        for (int s = 0; s < int'(v.count); s++) begin
          for (int i = 0; i < 512; i++) begin
            a = v.base + AW'(s * 512 + i);
            if (ram[a] !== (8'(i) ^ v.seed)) nmis++;
            ecs = ecs + {8'h00, (8'(i) ^ v.seed)};
          end
        end
        check($sformatf("t%0d_ram_data", t), nmis, 0);
`ifdef SD_LOADER_CHECKSUM_EN
        check($sformatf("t%0d_checksum", t), cs0, ecs);
`else
        check($sformatf("t%0d_checksum", t), cs0, 16'h0000);
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
